// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the AXI-Stream packet FIFO: byte-enable width and
// the width of one stored beat word {tlast, tkeep, tdata}.
package axis_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int word_w(input int data_w);
    return data_w + keep_w(data_w) + 1;
  endfunction

  localparam int DEF_WORD_W = word_w(DEF_DATA_WIDTH);

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage: one registered write port and one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int ADDR_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_DEPTH-1:0] waddr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [ADDR_DEPTH-1:0] raddr_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward release, level and
// packet counters, and almost-full/almost-empty flags.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_DEPTH       = 4,
  parameter int PACKET_MODE      = 0,
  parameter int ALMOST_FULL_LVL  = (2**ADDR_DEPTH) - 2,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [DATA_WIDTH-1:0]           s_tdata,
  input  logic [keep_w(DATA_WIDTH)-1:0]   s_tkeep,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic                            s_tlast,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [keep_w(DATA_WIDTH)-1:0]   m_tkeep,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [ADDR_DEPTH:0]             level,
  output logic [ADDR_DEPTH:0]             pkt_count,
  output logic                            almost_full,
  output logic                            almost_empty
);

  localparam int WORD_W = word_w(DATA_WIDTH);
  localparam logic [ADDR_DEPTH:0] DEPTH_C = (ADDR_DEPTH+1)'(2**ADDR_DEPTH);
  localparam logic [ADDR_DEPTH:0] ONE_C   = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH:0] AF_C    = (ADDR_DEPTH+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_DEPTH:0] AE_C    = (ADDR_DEPTH+1)'(ALMOST_EMPTY_LVL);
  localparam logic                CUT_C   = (PACKET_MODE == 0);

  logic [ADDR_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH:0] level_q, level_d;
  logic [ADDR_DEPTH:0] pkt_q, pkt_d;
  logic                bypass_q, bypass_d;
  logic                wr_en, rd_en, wr_last, rd_last;
  logic [WORD_W-1:0]   rd_word;

  assign s_tready = (level_q != DEPTH_C);
  // In store-and-forward mode a beat is released only once a whole packet is
  // stored, or when an over-long packet has filled the FIFO (bypass).
  assign m_tvalid = (level_q != '0) & (CUT_C | (pkt_q != '0) | bypass_q);
  assign wr_en    = s_tvalid & s_tready;
  assign rd_en    = m_tvalid & m_tready;
  assign wr_last  = wr_en & s_tlast;
  assign rd_last  = rd_en & m_tlast;

  assign {m_tlast, m_tkeep, m_tdata} = rd_word;
  assign level        = level_q;
  assign pkt_count    = pkt_q;
  assign almost_full  = (level_q >= AF_C);
  assign almost_empty = (level_q <= AE_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    bypass_d = bypass_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_en) rd_ptr_d = rd_ptr_q + ONE_C;
    if (wr_en && !rd_en)      level_d = level_q + ONE_C;
    else if (rd_en && !wr_en) level_d = level_q - ONE_C;
    if (wr_last && !rd_last)      pkt_d = pkt_q + ONE_C;
    else if (rd_last && !wr_last) pkt_d = pkt_q - ONE_C;
    if (level_q == DEPTH_C && pkt_q == '0) bypass_d = 1'b1;
    else if (rd_last)                      bypass_d = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      bypass_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      bypass_q <= bypass_d;
    end
  end

  axis_fifo_ram #(
    .WORD_W     (WORD_W),
    .ADDR_DEPTH (ADDR_DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_DEPTH-1:0]),
    .wdata_i ({s_tlast, s_tkeep, s_tdata}),
    .raddr_i (rd_ptr_q[ADDR_DEPTH-1:0]),
    .rdata_o (rd_word)
  );

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: lane 0 is cut-through, lane 1 store-and-forward,
// both DEPTH=16, each checked every cycle against a queue-based reference.
module tb_axis_pkt_fifo;

  typedef struct packed {
    logic       l;
    logic [0:0] k;
    logic [7:0] d;
  } beat_t;

  int checks = 0;
  int failures = 0;

  logic       aclk;
  logic       areset;
  logic [7:0] s_tdata  [2];
  logic [0:0] s_tkeep  [2];
  logic       s_tvalid [2];
  logic       s_tready [2];
  logic       s_tlast  [2];
  logic [7:0] m_tdata  [2];
  logic [0:0] m_tkeep  [2];
  logic       m_tvalid [2];
  logic       m_tready [2];
  logic       m_tlast  [2];
  logic [4:0] level    [2];
  logic [4:0] pkt_count[2];
  logic       almost_full [2];
  logic       almost_empty[2];
  int         rdy_mode [2];

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lane=%0d got=%0h exp=%0h t=%0t", nm, i, got, exp, $time);
    end
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  for (genvar g = 0; g < 2; g++) begin : lane
    axis_pkt_fifo #(
      .DATA_WIDTH (8),
      .ADDR_DEPTH (4),
      .PACKET_MODE(g)
    ) dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_tdata     (s_tdata[g]),
      .s_tkeep     (s_tkeep[g]),
      .s_tvalid    (s_tvalid[g]),
      .s_tready    (s_tready[g]),
      .s_tlast     (s_tlast[g]),
      .m_tdata     (m_tdata[g]),
      .m_tkeep     (m_tkeep[g]),
      .m_tvalid    (m_tvalid[g]),
      .m_tready    (m_tready[g]),
      .m_tlast     (m_tlast[g]),
      .level       (level[g]),
      .pkt_count   (pkt_count[g]),
      .almost_full (almost_full[g]),
      .almost_empty(almost_empty[g])
    );

    beat_t q[$];
    bit    byp = 1'b0;
    bit    armed = 1'b0;

    // Reference: contents are a queue; flags and counts follow from it.
    always @(negedge aclk) begin : mon
      int    n, np;
      bit    ev, popped_last;
      beat_t b;
      n = q.size();
      np = 0;
      foreach (q[j]) if (q[j].l) np++;
      ev = (n != 0) && ((g == 0) || (np != 0) || byp);
      popped_last = 1'b0;
      if (armed) begin
        chk("level", g, 32'(level[g]), 32'(n));
        chk("pkt_count", g, 32'(pkt_count[g]), 32'(np));
        chk("s_tready", g, 32'(s_tready[g]), 32'(n != 16));
        chk("m_tvalid", g, 32'(m_tvalid[g]), 32'(ev));
        chk("almost_full", g, 32'(almost_full[g]), 32'(n >= 14));
        chk("almost_empty", g, 32'(almost_empty[g]), 32'(n <= 2));
        if (ev && m_tvalid[g])
          chk("beat", g, 32'({m_tlast[g], m_tkeep[g], m_tdata[g]}), 32'(q[0]));
      end
      if (areset) begin
        q.delete();
        byp = 1'b0;
        armed = 1'b1;
      end else if (armed) begin
        if (ev && m_tready[g]) begin
          b = q.pop_front();
          popped_last = b.l;
        end
        if (s_tvalid[g] && n != 16) q.push_back({s_tlast[g], s_tkeep[g], s_tdata[g]});
        if (popped_last) byp = 1'b0;
        if (n == 16 && np == 0) byp = 1'b1;
      end
    end
  end

  initial begin
    m_tready[0] = 1'b0;
    m_tready[1] = 1'b0;
    forever begin
      @(posedge aclk);
      #2;
      for (int i = 0; i < 2; i++)
        m_tready[i] = (rdy_mode[i] == 2) ? 1'($urandom) : (rdy_mode[i] == 1);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic k, input logic l);
    bit acc;
    int t;
    s_tdata[i] = d;
    s_tkeep[i] = k;
    s_tlast[i] = l;
    s_tvalid[i] = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 1000) begin
      @(negedge aclk);
      acc = s_tready[i];
      tick();
      t++;
    end
    s_tvalid[i] = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout lane=%0d got=stalled exp=accepted t=%0t", i, $time);
    end
  endtask

  task automatic wait_empty(input int i);
    int t;
    t = 0;
    while (level[i] !== 5'd0 && t < 3000) begin
      tick();
      t++;
    end
    chk("drain", i, 32'(level[i]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int len;
    areset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i] = '0; s_tkeep[i] = '0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
      rdy_mode[i] = 0;
    end
    repeat (3) tick();
    areset = 1'b0;
    tick();

    // Cut-through: fill to full, then drain in order
    for (int j = 0; j < 16; j++) send(0, 8'(j + 8'h10), 1'b1, j == 15);
    chk("full_s_tready", 0, 32'(s_tready[0]), 32'd0);
    chk("full_level", 0, 32'(level[0]), 32'd16);
    chk("full_af", 0, 32'(almost_full[0]), 32'd1);
    rdy_mode[0] = 1;
    wait_empty(0);

    // Full with simultaneous write pressure and reads
    rdy_mode[0] = 0;
    for (int j = 0; j < 16; j++) send(0, 8'(j + 8'h40), 1'b1, 1'b0);
    rdy_mode[0] = 1;
    for (int j = 0; j < 8; j++) send(0, 8'(j + 8'h80), 1'b0, j == 7);
    wait_empty(0);

    // Cut-through random traffic
    rdy_mode[0] = 2;
    for (int j = 0; j < 200; j++) begin
      send(0, 8'($urandom), 1'($urandom), ($urandom % 4) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_empty(0);

    // Store-and-forward: 5-beat packet held until its tlast is written
    rdy_mode[1] = 1;
    for (int j = 0; j < 4; j++) send(1, 8'(j + 8'hA0), 1'b1, 1'b0);
    chk("sf_hold", 1, 32'(m_tvalid[1]), 32'd0);
    send(1, 8'hA4, 1'b1, 1'b1);
    chk("sf_release", 1, 32'(m_tvalid[1]), 32'd1);
    chk("sf_pkt1", 1, 32'(pkt_count[1]), 32'd1);
    wait_empty(1);
    chk("sf_pkt0", 1, 32'(pkt_count[1]), 32'd0);

    // Same-cycle tlast write and tlast read with two packets stored
    rdy_mode[1] = 0;
    send(1, 8'hB0, 1'b1, 1'b1);
    send(1, 8'hB1, 1'b0, 1'b1);
    rdy_mode[1] = 1;
    send(1, 8'hB2, 1'b0, 1'b1);
    chk("both_pkt", 1, 32'(pkt_count[1]), 32'd2);
    chk("both_level", 1, 32'(level[1]), 32'd2);
    wait_empty(1);

    // Packet longer than DEPTH must stream out through bypass
    for (int j = 0; j < 20; j++) send(1, 8'(j + 8'hC0), 1'b1, j == 19);
    wait_empty(1);

    // Reset mid-packet discards partial data on both lanes
    rdy_mode[0] = 0;
    for (int j = 0; j < 3; j++) send(0, 8'(j + 8'hD0), 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) send(1, 8'(j + 8'hD8), 1'b1, 1'b0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_level", i, 32'(level[i]), 32'd0);
      chk("rst_pkt", i, 32'(pkt_count[i]), 32'd0);
      chk("rst_m_tvalid", i, 32'(m_tvalid[i]), 32'd0);
      chk("rst_s_tready", i, 32'(s_tready[i]), 32'd1);
    end
    send(1, 8'hE0, 1'b1, 1'b0);
    send(1, 8'hE1, 1'b1, 1'b1);
    wait_empty(1);

    // Store-and-forward random packets, some longer than DEPTH
    rdy_mode[1] = 2;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) send(1, 8'($urandom), 1'($urandom), j == len - 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_empty(1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
